// File: rtl/sdram_arbiter_pkg.sv
// Shared SDRAM definitions: command encodings, bus widths and arbiter states.
package sdram_defs;

  localparam int CMD_W  = 4;
  localparam int BA_W   = 2;
  localparam int ADDR_W = 13;
  localparam int DQ_W   = 16;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [CMD_W-1:0] CMD_NOP  = 4'b0111;
  localparam logic [CMD_W-1:0] CMD_ACT  = 4'b0011;
  localparam logic [CMD_W-1:0] CMD_RD   = 4'b0101;
  localparam logic [CMD_W-1:0] CMD_WR   = 4'b0100;
  localparam logic [CMD_W-1:0] CMD_BST  = 4'b0110;
  localparam logic [CMD_W-1:0] CMD_PRE  = 4'b0010;
  localparam logic [CMD_W-1:0] CMD_AREF = 4'b0001;
  localparam logic [CMD_W-1:0] CMD_MRS  = 4'b0000;

  // Idle pin values presented whenever no master owns the bus.
  localparam logic [BA_W-1:0]   BA_IDLE   = 2'b11;
  localparam logic [ADDR_W-1:0] ADDR_IDLE = 13'h1FFF;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARBIT = 3'd1,
    AREF  = 3'd2,
    WRITE = 3'd3,
    READ  = 3'd4
  } state_t;

endpackage

// File: rtl/sdram_arbiter_if.sv
// Bundle of the four master buses and the SDRAM pin-side outputs.
interface sdram_arbiter_if;
  import sdram_defs::*;

  logic              init_end;
  logic [CMD_W-1:0]  init_cmd;
  logic [BA_W-1:0]   init_ba;
  logic [ADDR_W-1:0] init_addr;

  logic              aref_req;
  logic              aref_end;
  logic [CMD_W-1:0]  aref_cmd;
  logic [BA_W-1:0]   aref_ba;
  logic [ADDR_W-1:0] aref_addr;

  logic              wr_req;
  logic              wr_end;
  logic [CMD_W-1:0]  wr_cmd;
  logic [BA_W-1:0]   wr_ba;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_dq_oe;
  logic [DQ_W-1:0]   wr_dq;

  logic              rd_req;
  logic              rd_end;
  logic [CMD_W-1:0]  rd_cmd;
  logic [BA_W-1:0]   rd_ba;
  logic [ADDR_W-1:0] rd_addr;

  logic              aref_en;
  logic              wr_en;
  logic              rd_en;
  logic              timeout_err;
  logic              sdram_cke;
  logic              sdram_cs_n;
  logic              sdram_ras_n;
  logic              sdram_cas_n;
  logic              sdram_we_n;
  logic [BA_W-1:0]   sdram_bank;
  logic [ADDR_W-1:0] sdram_addr;
  logic [DQ_W-1:0]   sdram_dq_out;
  logic              sdram_dq_oe;

  // Arbiter side
  modport slave (
    input  init_end, init_cmd, init_ba, init_addr,
    input  aref_req, aref_end, aref_cmd, aref_ba, aref_addr,
    input  wr_req, wr_end, wr_cmd, wr_ba, wr_addr, wr_dq_oe, wr_dq,
    input  rd_req, rd_end, rd_cmd, rd_ba, rd_addr,
    output aref_en, wr_en, rd_en, timeout_err, sdram_cke,
    output sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
    output sdram_bank, sdram_addr, sdram_dq_out, sdram_dq_oe
  );

  // Master / environment side
  modport master (
    output init_end, init_cmd, init_ba, init_addr,
    output aref_req, aref_end, aref_cmd, aref_ba, aref_addr,
    output wr_req, wr_end, wr_cmd, wr_ba, wr_addr, wr_dq_oe, wr_dq,
    output rd_req, rd_end, rd_cmd, rd_ba, rd_addr,
    input  aref_en, wr_en, rd_en, timeout_err, sdram_cke,
    input  sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
    input  sdram_bank, sdram_addr, sdram_dq_out, sdram_dq_oe
  );

endinterface

// File: rtl/sdram_arbiter.sv
// SDRAM command-bus arbiter: init owns the bus until init_end, then refresh
// has priority and write/read alternate. All pin outputs are registered so
// every master sees the same one-cycle latency to the device.
module sdram_arbiter
  import sdram_defs::*;
#(
  parameter logic [15:0] TIMEOUT_CYC = 16'd4096
) (
  input logic           clk,
  input logic           rst,
  sdram_arbiter_if.slave bus
);

  state_t state, state_next;
  state_t last_grant;

  logic [15:0]       timer;
  logic              timeout_next;
  logic              timeout_reg;
  logic              timeout_hit;

  logic [CMD_W-1:0]  cmd_next,  cmd_reg;
  logic [BA_W-1:0]   ba_next,   ba_reg;
  logic [ADDR_W-1:0] addr_next, addr_reg;
  logic [DQ_W-1:0]   dq_next,   dq_reg;
  logic              oe_next,   oe_reg;

  // Forced release point: the last allowed cycle of any grant state.
  assign timeout_hit = (timer == TIMEOUT_CYC - 16'd1);

  // Next-state decision and pin mux for the owner of the current state.
  always_comb begin
    state_next   = state;
    timeout_next = 1'b0;
    cmd_next     = CMD_NOP;
    ba_next      = BA_IDLE;
    addr_next    = ADDR_IDLE;
    dq_next      = '0;
    oe_next      = 1'b0;
    case (state)
      IDLE: begin
        cmd_next  = bus.init_cmd;
        ba_next   = bus.init_ba;
        addr_next = bus.init_addr;
        if (bus.init_end) state_next = ARBIT;
      end
      ARBIT: begin
        if (bus.aref_req)                  state_next = AREF;
        else if (bus.wr_req && bus.rd_req) state_next = (last_grant == WRITE) ? READ : WRITE;
        else if (bus.wr_req)               state_next = WRITE;
        else if (bus.rd_req)               state_next = READ;
      end
      AREF: begin
        cmd_next  = bus.aref_cmd;
        ba_next   = bus.aref_ba;
        addr_next = bus.aref_addr;
        if (bus.aref_end) state_next = ARBIT;
        else if (timeout_hit) begin
          state_next   = ARBIT;
          timeout_next = 1'b1;
        end
      end
      WRITE: begin
        cmd_next  = bus.wr_cmd;
        ba_next   = bus.wr_ba;
        addr_next = bus.wr_addr;
        dq_next   = bus.wr_dq;
        oe_next   = bus.wr_dq_oe;
        if (bus.wr_end) state_next = ARBIT;
        else if (timeout_hit) begin
          state_next   = ARBIT;
          timeout_next = 1'b1;
        end
      end
      READ: begin
        cmd_next  = bus.rd_cmd;
        ba_next   = bus.rd_ba;
        addr_next = bus.rd_addr;
        if (bus.rd_end) state_next = ARBIT;
        else if (timeout_hit) begin
          state_next   = ARBIT;
          timeout_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State, alternation memory and grant timer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      last_grant  <= READ;
      timer       <= '0;
      timeout_reg <= 1'b0;
    end else begin
      state       <= state_next;
      timeout_reg <= timeout_next;
      if (state == ARBIT && (state_next == WRITE || state_next == READ))
        last_grant <= state_next;
      // Cleared while not granted so it starts at zero on grant entry.
      if (state == IDLE || state == ARBIT) timer <= '0;
      else                                 timer <= timer + 16'd1;
    end
  end

  // Registered device pins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_reg  <= CMD_NOP;
      ba_reg   <= BA_IDLE;
      addr_reg <= ADDR_IDLE;
      dq_reg   <= '0;
      oe_reg   <= 1'b0;
    end else begin
      cmd_reg  <= cmd_next;
      ba_reg   <= ba_next;
      addr_reg <= addr_next;
      dq_reg   <= dq_next;
      oe_reg   <= oe_next;
    end
  end

  assign bus.aref_en      = (state == AREF);
  assign bus.wr_en        = (state == WRITE);
  assign bus.rd_en        = (state == READ);
  assign bus.timeout_err  = timeout_reg;
  assign bus.sdram_cke    = 1'b1;
  assign {bus.sdram_cs_n, bus.sdram_ras_n, bus.sdram_cas_n, bus.sdram_we_n} = cmd_reg;
  assign bus.sdram_bank   = ba_reg;
  assign bus.sdram_addr   = addr_reg;
  assign bus.sdram_dq_out = dq_reg;
  assign bus.sdram_dq_oe  = oe_reg;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: init hand-off, priority, alternation,
// write data path, grant timeout and reset during a burst.
module tb_sdram_arbiter;
  import sdram_defs::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  sdram_arbiter_if bus();

  sdram_arbiter #(.TIMEOUT_CYC(16'd4096)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  wire [3:0] pin_cmd = {bus.sdram_cs_n, bus.sdram_ras_n, bus.sdram_cas_n, bus.sdram_we_n};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n clocks; return 1 ns after the last edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  task automatic chk_en(input string tag, input logic a, input logic w, input logic r);
    chk({tag, ".aref_en"}, 32'(bus.aref_en), 32'(a));
    chk({tag, ".wr_en"},   32'(bus.wr_en),   32'(w));
    chk({tag, ".rd_en"},   32'(bus.rd_en),   32'(r));
  endtask

  task automatic chk_nop(input string tag);
    chk({tag, ".cmd"},  32'(pin_cmd),         32'(CMD_NOP));
    chk({tag, ".bank"}, 32'(bus.sdram_bank),  32'h3);
    chk({tag, ".addr"}, 32'(bus.sdram_addr),  32'h1FFF);
    chk({tag, ".oe"},   32'(bus.sdram_dq_oe), 32'h0);
  endtask

  initial begin
    bus.init_end = 1'b0; bus.init_cmd = CMD_PRE; bus.init_ba = 2'b00; bus.init_addr = 13'h0400;
    bus.aref_req = 1'b0; bus.aref_end = 1'b0;
    bus.aref_cmd = CMD_AREF; bus.aref_ba = 2'b00; bus.aref_addr = 13'h0AAA;
    bus.wr_req = 1'b0; bus.wr_end = 1'b0;
    bus.wr_cmd = CMD_WR; bus.wr_ba = 2'b01; bus.wr_addr = 13'h0123;
    bus.wr_dq_oe = 1'b0; bus.wr_dq = 16'h0000;
    bus.rd_req = 1'b0; bus.rd_end = 1'b0;
    bus.rd_cmd = CMD_RD; bus.rd_ba = 2'b10; bus.rd_addr = 13'h0456;

    // Reset state
    tick(2);
    chk_nop("reset");
    chk_en("reset", 1'b0, 1'b0, 1'b0);
    chk("reset.timeout", 32'(bus.timeout_err), 32'h0);
    chk("reset.cke", 32'(bus.sdram_cke), 32'h1);
    chk("reset.dq", 32'(bus.sdram_dq_out), 32'h0);
    rst = 1'b0;

    // 1. Init master drives the pins one cycle later; init_end hands over.
    tick(1);
    chk("init.cmd", 32'(pin_cmd), 32'(CMD_PRE));
    chk("init.addr", 32'(bus.sdram_addr), 32'h0400);
    chk("init.bank", 32'(bus.sdram_bank), 32'h0);
    bus.init_end = 1'b1;
    tick(2);
    chk_nop("arbit");
    chk_en("arbit", 1'b0, 1'b0, 1'b0);

    // 2. All three request: refresh wins.
    bus.aref_req = 1'b1; bus.wr_req = 1'b1; bus.rd_req = 1'b1;
    tick(1);
    chk_en("prio", 1'b1, 1'b0, 1'b0);
    chk("prio.nop_first", 32'(pin_cmd), 32'(CMD_NOP));
    tick(1);
    chk("aref.cmd", 32'(pin_cmd), 32'(CMD_AREF));
    chk("aref.addr", 32'(bus.sdram_addr), 32'h0AAA);
    bus.wr_end = 1'b1;  // non-granted end must be ignored
    tick(1);
    chk_en("ignore_end", 1'b1, 1'b0, 1'b0);
    bus.wr_end = 1'b0; bus.aref_end = 1'b1; bus.aref_req = 1'b0;
    tick(1);
    bus.aref_end = 1'b0;
    chk_en("aref_done", 1'b0, 1'b0, 1'b0);
    tick(1);
    chk_en("first_wr", 1'b0, 1'b1, 1'b0);

    // 3. Both held: alternation with a NOP cycle between grants.
    tick(1);
    chk("wr.cmd", 32'(pin_cmd), 32'(CMD_WR));
    chk("wr.bank", 32'(bus.sdram_bank), 32'h1);
    bus.wr_end = 1'b1;
    tick(1);
    bus.wr_end = 1'b0;
    chk_en("gap1", 1'b0, 1'b0, 1'b0);
    tick(1);
    chk_en("alt_rd", 1'b0, 1'b0, 1'b1);
    chk_nop("gap1.pins");
    bus.rd_end = 1'b1;
    tick(1);
    bus.rd_end = 1'b0;
    chk_en("gap2", 1'b0, 1'b0, 1'b0);
    chk("rd.cmd", 32'(pin_cmd), 32'(CMD_RD));
    tick(1);
    chk_en("alt_wr", 1'b0, 1'b1, 1'b0);

    // 4. Write data path aligned with the command.
    bus.wr_dq = 16'hA5A5; bus.wr_dq_oe = 1'b1;
    tick(1);
    chk("wdata.cmd", 32'(pin_cmd), 32'(CMD_WR));
    chk("wdata.dq", 32'(bus.sdram_dq_out), 32'hA5A5);
    chk("wdata.oe", 32'(bus.sdram_dq_oe), 32'h1);
    bus.wr_end = 1'b1;
    tick(1);
    bus.wr_end = 1'b0;
    tick(1);
    chk_en("alt_rd2", 1'b0, 1'b0, 1'b1);
    bus.wr_req = 1'b0; bus.rd_req = 1'b0;
    tick(1);
    chk("rd.oe", 32'(bus.sdram_dq_oe), 32'h0);
    chk("rd.dq", 32'(bus.sdram_dq_out), 32'h0);
    chk("rd.cmd2", 32'(pin_cmd), 32'(CMD_RD));

    // 5. Withhold rd_end: forced release after 4096 grant cycles.
    tick(4094);
    chk_en("to.before", 1'b0, 1'b0, 1'b1);
    chk("to.before.err", 32'(bus.timeout_err), 32'h0);
    tick(1);
    chk_en("to.release", 1'b0, 1'b0, 1'b0);
    chk("to.pulse", 32'(bus.timeout_err), 32'h1);
    tick(1);
    chk("to.pulse_end", 32'(bus.timeout_err), 32'h0);

    // 6. Reset in the middle of a write burst.
    bus.wr_req = 1'b1;
    tick(1);
    chk_en("wr3", 1'b0, 1'b1, 1'b0);
    tick(1);
    chk("wr3.oe", 32'(bus.sdram_dq_oe), 32'h1);
    #2 rst = 1'b1;
    #1;
    chk_nop("rst_mid");
    chk_en("rst_mid", 1'b0, 0, 1'b0);
    chk("rst_mid.dq", 32'(bus.sdram_dq_out), 32'h0);
    tick(1);
    rst = 1'b0;
    bus.wr_req = 1'b0;
    tick(1);
    chk("rst_idle.cmd", 32'(pin_cmd), 32'(CMD_PRE));
    chk_en("rst_idle", 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
